// File: rtl/uart_tx_framer.sv
// Asynchronous-serial transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Runs on the oversampled UART clock with a level request/done handshake.
module uart_tx_framer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_done,
  output logic       tx_busy
);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_tx_framer: OVERSAMPLE must be 4..64");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  // The tick counter must also span the whole stop interval when STOP_BITS=2.
  localparam int TICK_W = $clog2(STOP_BITS * OVERSAMPLE);
  localparam logic [TICK_W-1:0] BIT_END  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_END = TICK_W'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_out_q, tx_out_d;
  logic                   tx_done_q, tx_done_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   bit_end;
  logic                   tx_data_unused;

  // Upper tx_data bits are don't-care for narrow frames.
  assign tx_data_unused = ^tx_data;
  assign bit_end        = (tick_q == BIT_END);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d = tx_data[DATA_BITS-1:0];
          par_d   = (PARITY == 1) ? ~^tx_data[DATA_BITS-1:0] : ^tx_data[DATA_BITS-1:0];
          tick_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tick_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_q == STOP_END) begin
          tick_d  = '0;
          state_d = S_DONE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!tx_start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so the line changes on the bit boundary.
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = par_d;
      default:  tx_out_d = 1'b1;
    endcase
    tx_done_d = (state_d == S_DONE);
    tx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      tx_out_q  <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      tx_out_q  <= tx_out_d;
      tx_done_q <= tx_done_d;
      tx_busy_q <= tx_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx_out  = tx_out_q;
  assign tx_done = tx_done_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four framings side by side, each frame compared against
// a waveform built from the frame format rules.
module tb_uart_tx_framer;

  localparam int OS = 16;
  localparam int NU = 4;
  localparam int DB[NU]  = '{8, 8, 8, 7};
  localparam int PAR[NU] = '{0, 2, 1, 0};
  localparam int SB[NU]  = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       start[NU];
  logic [7:0] data[NU];
  logic       out[NU];
  logic       done[NU];
  logic       busy[NU];

  int checks = 0;
  int errors = 0;

  uart_tx_framer #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(data[0]),
    .tx_out(out[0]), .tx_done(done[0]), .tx_busy(busy[0]));
  uart_tx_framer #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(data[1]),
    .tx_out(out[1]), .tx_done(done[1]), .tx_busy(busy[1]));
  uart_tx_framer #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(data[2]),
    .tx_out(out[2]), .tx_done(done[2]), .tx_busy(busy[2]));
  uart_tx_framer #(.OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(data[3]),
    .tx_out(out[3]), .tx_done(done[3]), .tx_busy(busy[3]));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int frame_len(input int u);
    return OS * (1 + DB[u] + ((PAR[u] != 0) ? 1 : 0) + SB[u]);
  endfunction

  // Line level for every cycle of the frame, starting with the cycle after acceptance.
  function automatic logic [255:0] model_wave(input int u, input logic [7:0] d);
    int bits[$];
    int ones;
    logic [255:0] w;
    ones = 0;
    bits.push_back(0);
    for (int i = 0; i < DB[u]; i++) begin
      bits.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (PAR[u] == 1) bits.push_back((ones % 2 == 0) ? 1 : 0);
    if (PAR[u] == 2) bits.push_back(ones % 2);
    for (int i = 0; i < SB[u]; i++) bits.push_back(1);
    w = '0;
    for (int c = 0; c < bits.size() * OS; c++) w[c] = bits[c / OS][0];
    return w;
  endfunction

  task automatic run_frame(input int u, input logic [7:0] d, input int chg_at,
                           input logic [7:0] chg_d, input int drop_at);
    logic [255:0] exp_w;
    logic [255:0] cap;
    int len;
    int done_at;
    int busy_low;
    len      = frame_len(u);
    exp_w    = model_wave(u, d);
    cap      = '0;
    done_at  = -1;
    busy_low = 0;
    data[u]  = d;
    start[u] = 1'b1;
    for (int c = 0; c <= len; c++) begin
      tick();
      if (c < len) begin
        cap[c] = out[u];
        if (busy[u] !== 1'b1) busy_low++;
      end
      if (done[u] === 1'b1 && done_at < 0) done_at = c;
      if (c == chg_at) data[u] = chg_d;
      if (c == drop_at) start[u] = 1'b0;
    end
    checks++;
    if (cap !== exp_w) begin
      errors++;
      $display("FAIL frame_bits unit=%0d data=%h got=%h exp=%h", u, d, cap, exp_w);
    end
    checks++;
    if (done_at !== len) begin
      errors++;
      $display("FAIL done_time unit=%0d got=%0d exp=%0d", u, done_at, len);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL busy_in_frame unit=%0d low_cycles=%0d exp=0", u, busy_low);
    end
    if (drop_at >= 0) begin
      tick();
      checks++;
      if ({out[u], done[u], busy[u]} !== 3'b100) begin
        errors++;
        $display("FAIL done_pulse unit=%0d out/done/busy=%b exp=100", u,
                 {out[u], done[u], busy[u]});
      end
    end
  endtask

  task automatic release_done(input int u);
    start[u] = 1'b0;
    tick();
    checks++;
    if ({out[u], done[u], busy[u]} !== 3'b100) begin
      errors++;
      $display("FAIL release unit=%0d out/done/busy=%b exp=100", u, {out[u], done[u], busy[u]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      start[u] = 1'b0;
      data[u]  = 8'h00;
    end
    tick();
    tick();
    for (int u = 0; u < NU; u++) begin
      checks++;
      if ({out[u], done[u], busy[u]} !== 3'b100) begin
        errors++;
        $display("FAIL reset unit=%0d out/done/busy=%b exp=100", u, {out[u], done[u], busy[u]});
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_frame(0, 8'h55, -1, 8'h00, -1);
    tick();
    checks++;
    if ({out[0], done[0], busy[0]} !== 3'b111) begin
      errors++;
      $display("FAIL done_hold out/done/busy=%b exp=111", {out[0], done[0], busy[0]});
    end
    release_done(0);
  endtask

  task automatic test_hold_and_restart();
    int bad;
    run_frame(0, 8'($urandom), -1, 8'h00, -1);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (out[0] !== 1'b1 || done[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_no_resend bad_cycles=%0d exp=0", bad);
    end
    release_done(0);
    run_frame(0, 8'($urandom), -1, 8'h00, -1);
    release_done(0);
  endtask

  task automatic test_reset_midframe();
    data[0]  = 8'h00;
    start[0] = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset got=%b exp=1", busy[0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out[0], done[0], busy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL midframe_reset out/done/busy=%b exp=100", {out[0], done[0], busy[0]});
    end
    rst = 1'b0;
    run_frame(0, 8'($urandom), -1, 8'h00, -1);
    release_done(0);
  endtask

  task automatic test_data_change();
    run_frame(0, 8'h0F, 20, 8'hF0, 30);
  endtask

  task automatic test_parity();
    run_frame(1, 8'hA3, -1, 8'h00, 5);
    run_frame(2, 8'hA3, -1, 8'h00, 5);
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 8'($urandom), -1, 8'h00, 7);
      run_frame(2, 8'($urandom), -1, 8'h00, 7);
    end
  endtask

  task automatic test_stop2();
    run_frame(3, 8'hFF, -1, 8'h00, 5);
    for (int i = 0; i < 3; i++) run_frame(3, 8'($urandom), -1, 8'h00, 9);
  endtask

  task automatic test_back_to_back();
    int u;
    for (int i = 0; i < 8; i++) begin
      u = int'($urandom_range(0, NU - 1));
      if ($urandom_range(0, 1) == 1) begin
        run_frame(u, 8'($urandom), int'($urandom_range(0, 100)), 8'($urandom),
                  int'($urandom_range(0, 50)));
      end else begin
        run_frame(u, 8'($urandom), int'($urandom_range(0, 100)), 8'($urandom), -1);
        release_done(u);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_and_restart();
    test_reset_midframe();
    test_data_change();
    test_parity();
    test_stop2();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Standalone asynchronous-serial transmitter. Serialises one parallel word per request onto a single line: start bit, data LSB first, optional parity, stop bit(s).
- Clocked by the 16x-oversampled UART clock, 921.6 kHz for 57600 baud. The same fractional-accumulator clock feeds the rest of the UART path.
- Drop-in for the transmit side of the echo path. Uses the same level handshake: request held until done, done held until request drops.

Parameters:
- OVERSAMPLE, 16: clock cycles per bit period; legal range 4..64.
- DATA_BITS, 8: data bits per frame; legal range 5..8. Bits above DATA_BITS-1 of tx_data are ignored.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Any other value is an elaboration error.
- STOP_BITS, 1: 1 or 2 stop bit periods.

Ports:
- clk  in  1  oversampled UART clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  level request; held high by the initiator until tx_done is seen.
- tx_data  in  8  word to send; sampled only on the accepting edge.
- tx_out  out  1  serial line; idles high.
- tx_done  out  1  frame complete; held until tx_start is low.
- tx_busy  out  1  high from the accepting edge until return to IDLE.

Behaviour:
- Reset (rst=1 at an edge): tx_out=1, tx_done=0, tx_busy=0, state=IDLE, bit and tick counters cleared. Reset applies mid-frame too: the line returns high on the next cycle and the partial frame is abandoned.
- States are IDLE, START, DATA, PARITY, STOP, DONE. PARITY is skipped when PARITY=0.
- IDLE: tx_out=1.
  - Edge E0 with tx_start=1: latch tx_data[DATA_BITS-1:0] into a shift register.
  - Compute parity over the latched bits: odd means the total count of ones, including the parity bit, is odd.
  - Go to START; tx_busy=1 from E0.
- Timing: each bit state drives tx_out for exactly OVERSAMPLE cycles, counted by a tick counter running 0..OVERSAMPLE-1. The state advances when the tick counter reaches OVERSAMPLE-1.
- START: tx_out=0. The first low cycle is the cycle following E0.
- DATA: bit 0 first, then shift right. A bit counter runs 0..DATA_BITS-1. After the last bit, go to PARITY or STOP.
- PARITY: tx_out=parity bit for one bit period.
- STOP: tx_out=1 for STOP_BITS*OVERSAMPLE cycles. Go to DONE.
- DONE: tx_out=1, tx_done=1, tx_busy=1.
  - tx_start=0 at an edge: go to IDLE; tx_done=0 and tx_busy=0 from that edge.
  - tx_start=1: remain in DONE. No second frame is sent without a low phase on tx_start.
- Frame length: tx_out falls one cycle after E0. tx_done rises exactly OVERSAMPLE*(1+DATA_BITS+P+STOP_BITS) cycles after that, where P=1 if parity is enabled.
- Inputs during a frame: tx_data changes after E0 have no effect. If tx_start drops mid-frame, the frame still completes; DONE then sees tx_start=0, so tx_done is high for one cycle.
- Back-to-back: the minimum gap between frames is the DONE cycle plus one IDLE cycle, during which tx_out stays high.
- Counters never wrap: the tick counter reloads to 0 at every bit boundary and the bit counter is cleared on entry to DATA.
- Undefined states: recover to IDLE with tx_out=1. Never drive x.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16), tx_data=0x55 held, tx_start=1:
  - tx_out low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high.
  - tx_done rises 160 cycles after the falling edge of tx_out.
  - tx_start=0 → tx_done and tx_busy go 0 on the next edge.
- PARITY=2, tx_data=0xA3: data bits 1,1,0,0,0,1,0,1, parity bit 0, tx_done at 176 cycles. The same stimulus with PARITY=1 gives parity bit 1.
- STOP_BITS=2, DATA_BITS=7, tx_data=0xFF:
  - Only 7 data bits (all 1) are sent, and the line stays high for 32 stop cycles.
  - tx_done at 16*(1+7+2)=160 cycles.
- tx_start held high after tx_done=1 for 500 cycles → tx_out stays 1, no new start bit, tx_done stays 1.
  - Then tx_start low for one cycle and high again → new start bit 2 cycles after the re-assertion edge.
- rst=1 at cycle 40 of a 0x00 frame → tx_out=1, tx_done=0, tx_busy=0 next cycle.
  - After rst drops with tx_start=1 → fresh frame starting with a full 16-cycle start bit.
- tx_data changed from 0x0F to 0xF0 at cycle 20 of a frame, with tx_start dropped at cycle 30:
  - The transmitted bits match 0x0F.
  - tx_done is high for exactly one cycle at 160.
